// File: rtl/spi_master.sv
// SPI mode-3 master: one transfer of 1..32 bits per request, MSB (bit [nbits]) first.
// Every phase (lead, sclk low, sclk high, trail) lasts HALF_PERIOD clk_in cycles.
module spi_master #(
  parameter int HALF_PERIOD = 4
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [31:0] spi_mosi_data,
  input  logic [5:0]  spi_nbits,
  input  logic        spi_request,
  output logic [31:0] spi_miso_data,
  output logic        spi_ready,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEAD  = 3'd1;
  localparam logic [2:0] S_LOW   = 3'd2;
  localparam logic [2:0] S_HIGH  = 3'd3;
  localparam logic [2:0] S_TRAIL = 3'd4;

  localparam logic [7:0] HP_LAST = 8'(HALF_PERIOD - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  hp_q, hp_d;
  logic [4:0]  bit_q, bit_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] miso_data_q, miso_data_d;
  logic        ready_q, ready_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;

  logic        hp_end;
  logic [4:0]  bit_dec;
  logic        unused_nbits;

  assign hp_end       = (hp_q == HP_LAST);
  assign bit_dec      = bit_q - 5'd1;
  assign unused_nbits = spi_nbits[5];

  always_comb begin
    state_d     = state_q;
    hp_d        = hp_end ? 8'd0 : hp_q + 8'd1;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    miso_data_d = miso_data_q;
    ready_d     = 1'b0;
    cs_n_d      = cs_n_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    case (state_q)
      S_IDLE: begin
        // Phase counter parks at zero so LEAD always gets a full half-period.
        hp_d   = 8'd0;
        cs_n_d = 1'b1;
        sclk_d = 1'b1;
        mosi_d = 1'b0;
        if (spi_request) begin
          tx_d    = spi_mosi_data;
          bit_d   = spi_nbits[4:0];
          rx_d    = '0;
          cs_n_d  = 1'b0;
          state_d = S_LEAD;
        end
      end
      S_LEAD: if (hp_end) begin
        sclk_d  = 1'b0;
        mosi_d  = tx_q[bit_q];
        state_d = S_LOW;
      end
      S_LOW: if (hp_end) begin
        sclk_d  = 1'b1;
        rx_d    = {rx_q[30:0], spi_miso};
        state_d = S_HIGH;
      end
      S_HIGH: if (hp_end) begin
        if (bit_q != 5'd0) begin
          bit_d   = bit_dec;
          sclk_d  = 1'b0;
          mosi_d  = tx_q[bit_dec];
          state_d = S_LOW;
        end else begin
          state_d = S_TRAIL;
        end
      end
      S_TRAIL: if (hp_end) begin
        cs_n_d      = 1'b1;
        mosi_d      = 1'b0;
        miso_data_d = rx_q;
        ready_d     = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hp_q        <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      miso_data_q <= '0;
      ready_q     <= 1'b0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b1;
      mosi_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hp_q        <= hp_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      miso_data_q <= miso_data_d;
      ready_q     <= ready_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
    end
  end

  assign spi_miso_data = miso_data_q;
  assign spi_ready     = ready_q;
  assign spi_cs_n      = cs_n_q;
  assign spi_sclk      = sclk_q;
  assign spi_mosi      = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: HALF_PERIOD=4 and HALF_PERIOD=1 instances behind one mode-3 slave
// model; expected words and timings are queued at request time and checked at spi_ready.
module tb_spi_master;

  logic clk_in = 1'b0;
  logic rst;
  logic [31:0] mosi_data;
  logic [5:0]  nbits;
  logic        req;
  logic        miso;
  logic        sel;

  logic [31:0] md4, md1;
  logic        rdy4, rdy1, cs4, cs1, sclk4, sclk1, mosi4, mosi1;
  logic [31:0] o_md;
  logic        o_rdy, o_cs, o_sclk, o_mosi;

  always #5 clk_in = ~clk_in;

  spi_master #(.HALF_PERIOD(4)) dut4 (
    .clk_in(clk_in), .rst(rst), .spi_mosi_data(mosi_data), .spi_nbits(nbits),
    .spi_request(req & ~sel), .spi_miso_data(md4), .spi_ready(rdy4), .spi_cs_n(cs4),
    .spi_sclk(sclk4), .spi_mosi(mosi4), .spi_miso(miso));

  spi_master #(.HALF_PERIOD(1)) dut1 (
    .clk_in(clk_in), .rst(rst), .spi_mosi_data(mosi_data), .spi_nbits(nbits),
    .spi_request(req & sel), .spi_miso_data(md1), .spi_ready(rdy1), .spi_cs_n(cs1),
    .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_miso(miso));

  assign o_md   = sel ? md1   : md4;
  assign o_rdy  = sel ? rdy1  : rdy4;
  assign o_cs   = sel ? cs1   : cs4;
  assign o_sclk = sel ? sclk1 : sclk4;
  assign o_mosi = sel ? mosi1 : mosi4;

  // Slave: presents resp[n-1..0] MSB first, samples MOSI on rising SCLK.
  logic [31:0] resp;
  logic        loopb;
  int          cur_n;
  int          idx;
  logic [31:0] slv_rx;

  always @(negedge o_cs) begin
    idx    = cur_n - 1;
    slv_rx = '0;
  end
  always @(posedge o_sclk) if (!o_cs) begin
    slv_rx = {slv_rx[30:0], o_mosi};
    idx    = idx - 1;
  end
  assign miso = loopb ? o_mosi : ((idx >= 0) ? resp[idx[4:0]] : 1'b0);

  typedef struct {
    logic [31:0] miso;
    logic [31:0] mosi;
    int          cs_cyc;
    int          rises;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] nx_data, nx_resp;
  logic [5:0]  nx_nb;
  logic        nx_loop;
  int          nx_hp;

  // Called at a negedge: queues the expectation and raises the request for one edge.
  task automatic start_xfer(input logic [31:0] data, input logic [5:0] nb,
                            input logic [31:0] r, input logic lp, input int hp);
    int n;
    logic [31:0] mask;
    exp_t e;
    n = int'(nb[4:0]) + 1;
    mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    e.mosi   = data & mask;
    e.miso   = lp ? (data & mask) : (r & mask);
    e.cs_cyc = (2 * n + 2) * hp;
    e.rises  = n;
    sb.push_back(e);
    mosi_data = data;
    nbits     = nb;
    resp      = r;
    loopb     = lp;
    cur_n     = n;
    req       = 1'b1;
  endtask

  task automatic run_xfer(input string name, input bit inject, input bit chain, input bit chained_in);
    int cyc, cs_low, rises, mosi_bad, rdy_after;
    logic prev_sclk, prev_mosi;
    bit got;
    exp_t e;
    cyc = 0; cs_low = 0; rises = 0; mosi_bad = 0; got = 0;
    prev_sclk = 1'b1; prev_mosi = 1'b0;
    while (!got && cyc < 1000) begin
      @(negedge clk_in);
      cyc++;
      if (cyc == 1) begin
        mosi_data = ~mosi_data;
        nbits     = ~nbits;
        if (chained_in) begin
          n_chk++;
          if (o_cs !== 1'b0 || o_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_b2b_gap: cs_n=%b ready=%b, want cs_n=0 ready=0", name, o_cs, o_rdy);
          end
        end
      end
      if (o_cs === 1'b0) cs_low++;
      if (!prev_sclk && o_sclk) rises++;
      if (o_cs === 1'b0 && o_mosi !== prev_mosi && !(prev_sclk && !o_sclk)) mosi_bad++;
      prev_sclk = o_sclk;
      prev_mosi = o_mosi;
      req = inject && (o_cs === 1'b0) && (cyc % 5 == 2);
      if (o_rdy === 1'b1) got = 1;
    end
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s_timeout: no spi_ready within %0d cycles", name, cyc);
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s_sb: spi_ready with empty scoreboard", name);
    end else begin
      e = sb.pop_front();
      n_chk++;
      if (o_md !== e.miso) begin
        n_fail++; $display("FAIL %s_miso_data: got %h want %h", name, o_md, e.miso);
      end
      n_chk++;
      if (cs_low != e.cs_cyc) begin
        n_fail++; $display("FAIL %s_cs_low: got %0d want %0d cycles", name, cs_low, e.cs_cyc);
      end
      n_chk++;
      if (o_cs !== 1'b1) begin
        n_fail++; $display("FAIL %s_cs_at_ready: got %b want 1", name, o_cs);
      end
      n_chk++;
      if (rises != e.rises) begin
        n_fail++; $display("FAIL %s_sclk_rises: got %0d want %0d", name, rises, e.rises);
      end
      n_chk++;
      if (slv_rx !== e.mosi) begin
        n_fail++; $display("FAIL %s_mosi_stream: got %h want %h", name, slv_rx, e.mosi);
      end
      n_chk++;
      if (mosi_bad != 0) begin
        n_fail++; $display("FAIL %s_mosi_timing: %0d changes off falling sclk, want 0", name, mosi_bad);
      end
      if (chain) begin
        start_xfer(nx_data, nx_nb, nx_resp, nx_loop, nx_hp);
      end else begin
        rdy_after = 0;
        repeat (4) begin
          @(negedge clk_in);
          if (o_rdy !== 1'b0) rdy_after++;
        end
        n_chk++;
        if (rdy_after != 0 || o_cs !== 1'b1) begin
          n_fail++;
          $display("FAIL %s_after: extra ready=%0d cs_n=%b, want 0 and 1", name, rdy_after, o_cs);
        end
        n_chk++;
        if (o_md !== e.miso) begin
          n_fail++; $display("FAIL %s_hold: got %h want %h", name, o_md, e.miso);
        end
      end
    end
  endtask

  task automatic check_idle_outs(input string name, input logic [31:0] md, input logic r,
                                 input logic c, input logic s, input logic m);
    n_chk++;
    if (md !== 32'h0 || r !== 1'b0 || c !== 1'b1 || s !== 1'b1 || m !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: md=%h rdy=%b cs_n=%b sclk=%b mosi=%b, want 0 0 1 1 0", name, md, r, c, s, m);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 1'b0; sel = 1'b0; mosi_data = '0; nbits = '0;
    resp = '0; loopb = 1'b0; cur_n = 1;
    #2;
    check_idle_outs("reset_hp4", md4, rdy4, cs4, sclk4, mosi4);
    check_idle_outs("reset_hp1", md1, rdy1, cs1, sclk1, mosi1);
    repeat (3) @(negedge clk_in);
    rst = 1'b0;
    repeat (2) @(negedge clk_in);
    check_idle_outs("idle_after_reset", md4, rdy4, cs4, sclk4, mosi4);
  endtask

  task automatic test_who_am_i;
    sel = 1'b0;
    @(negedge clk_in);
    start_xfer(32'h0000_8F00, 6'd15, 32'h0000_0033, 1'b0, 4);
    run_xfer("whoami", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_three_byte;
    @(negedge clk_in);
    start_xfer(32'h00E8_0000, 6'd23, 32'h0000_12F4, 1'b0, 4);
    run_xfer("three_byte", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_length_bounds;
    @(negedge clk_in);
    start_xfer(32'h0000_0000, 6'd0, 32'h0000_0001, 1'b0, 4);
    run_xfer("len1_one", 1'b0, 1'b0, 1'b0);
    @(negedge clk_in);
    start_xfer(32'hFFFF_FFFF, 6'd0, 32'hFFFF_FFFE, 1'b0, 4);
    run_xfer("len1_zero", 1'b0, 1'b0, 1'b0);
    @(negedge clk_in);
    start_xfer(32'h0000_0001, 6'h20, 32'h0000_0001, 1'b0, 4);
    run_xfer("nbits_bit5", 1'b0, 1'b0, 1'b0);
    @(negedge clk_in);
    start_xfer(32'hA5A5_A5A5, 6'd31, 32'h0, 1'b1, 4);
    run_xfer("loop32", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_ignore_request;
    @(negedge clk_in);
    start_xfer(32'h0000_C3A5, 6'd15, 32'h0000_5A5A, 1'b0, 4);
    run_xfer("ignore_req", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    nx_data = 32'h0000_3C69; nx_nb = 6'd13; nx_resp = 32'h0000_2B17; nx_loop = 1'b0; nx_hp = 4;
    @(negedge clk_in);
    start_xfer(32'h0000_00F1, 6'd7, 32'h0000_009D, 1'b0, 4);
    run_xfer("b2b_first", 1'b0, 1'b1, 1'b0);
    run_xfer("b2b_second", 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid;
    int cyc, rises, rdy_cnt;
    logic prev_sclk;
    @(negedge clk_in);
    start_xfer(32'h0000_BEEF, 6'd15, 32'h0000_1111, 1'b0, 4);
    cyc = 0; rises = 0; prev_sclk = 1'b1;
    while (rises < 5 && cyc < 500) begin
      @(negedge clk_in);
      cyc++;
      req = 1'b0;
      if (!prev_sclk && o_sclk) rises++;
      prev_sclk = o_sclk;
    end
    n_chk++;
    if (rises < 5) begin
      n_fail++; $display("FAIL rst_mid_reach: got %0d rises want 5", rises);
    end
    #2 rst = 1'b1;
    #1;
    check_idle_outs("rst_mid_async", md4, rdy4, cs4, sclk4, mosi4);
    void'(sb.pop_back());
    rdy_cnt = 0;
    repeat (3) begin
      @(negedge clk_in);
      if (o_rdy !== 1'b0) rdy_cnt++;
    end
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk_in);
      if (o_rdy !== 1'b0) rdy_cnt++;
    end
    n_chk++;
    if (rdy_cnt != 0) begin
      n_fail++; $display("FAIL rst_mid_no_ready: got %0d pulses want 0", rdy_cnt);
    end
    @(negedge clk_in);
    start_xfer(32'h0000_9ABC, 6'd15, 32'h0000_6E2D, 1'b0, 4);
    run_xfer("after_rst", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      start_xfer($urandom, 6'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)), 4);
      run_xfer("random", 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_half_period_1;
    sel = 1'b1;
    @(negedge clk_in);
    start_xfer(32'h0000_1234, 6'd15, 32'h0, 1'b1, 1);
    run_xfer("hp1_loop16", 1'b0, 1'b0, 1'b0);
    @(negedge clk_in);
    start_xfer(32'h8C3E_5D71, 6'd31, 32'h0, 1'b1, 1);
    run_xfer("hp1_loop32", 1'b0, 1'b0, 1'b0);
    sel = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_who_am_i();
    test_three_byte();
    test_length_bounds();
    test_ignore_request();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_half_period_1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
